input_conditioner: RTL and testbench

Front-end for the scroll controller. Takes the raw, asynchronous pause push-button and the raw student-select slide switch. For each one it synchronises, then debounces. It outputs a single-cycle pause pulse on the debounced rising edge and a clean debounced student-select level. These outputs drive the controller's pulse_pause and sw_student inputs directly.

---
 rtl/input_conditioner_pkg.sv | 13 +
 rtl/input_conditioner_debounce_channel.sv | 61 ++++++
 rtl/input_conditioner.sv | 54 +++++
 tb/tb_input_conditioner.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the pause-button / student-switch input conditioner.
package input_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int DEBOUNCE_CYCLES_SIM     = 4;

  // Debounce counter width; the terminal count is DEBOUNCE_CYCLES-1, so clog2 suffices.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One input channel: multi-flop synchroniser followed by a consecutive-disagreement debouncer.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out_s;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   stable_q;
  logic                   stable_d;

  assign sync_out_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  // Any agreement with the stable value clears the count, so short bounces never qualify.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_out_s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_out_s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level_out = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the raw pause button and student switch into a clean pause pulse and student level.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pause_raw,
  input  logic sw_student_raw,
  output logic pulse_pause,
  output logic sw_student,
  output logic btn_pause_level
);

  logic pause_level_s;
  logic student_level_s;
  logic pause_dly_q;

  debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pause (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (btn_pause_raw),
    .level_out (pause_level_s)
  );

  debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_student (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (sw_student_raw),
    .level_out (student_level_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_dly_q <= 1'b0;
    end else begin
      pause_dly_q <= pause_level_s;
    end
  end

  // Both terms are flop outputs, so the pulse is glitch-free and lasts one cycle per rise.
  assign pulse_pause     = pause_level_s & ~pause_dly_q;
  assign btn_pause_level = pause_level_s;
  assign sw_student      = student_level_s;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with a sliding-window reference model.
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int S = SYNC_STAGES_DEFAULT;
  localparam int D = DEBOUNCE_CYCLES_SIM;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_pause_raw = 1'b0;
  logic sw_student_raw = 1'b0;
  logic pulse_pause, sw_student, btn_pause_level;

  int passed = 0;
  int total  = 0;
  int pulses = 0;

  input_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_pause_raw   (btn_pause_raw),
    .sw_student_raw  (sw_student_raw),
    .pulse_pause     (pulse_pause),
    .sw_student      (sw_student),
    .btn_pause_level (btn_pause_level)
  );

  always #5 clk = ~clk;

  // Reference model: history of raw samples per edge since reset. The synchronised value
  // seen before edge j is the raw sample taken at edge j-S (0 before reset release). The
  // stable level flips at an edge when the last D synchronised values all disagree with it.
  bit   btn_hist[$];
  bit   sw_hist[$];
  logic m_btn = 1'b0, m_sw = 1'b0, m_pulse = 1'b0;

  function automatic bit settled(input bit h[$], input logic cur);
    for (int t = 0; t < D; t++) begin
      int idx;
      bit v;
      idx = h.size() - 1 - S - t;
      v = (idx >= 0) ? h[idx] : 1'b0;
      if (v == cur) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_hist.delete();
      sw_hist.delete();
      m_btn   <= 1'b0;
      m_sw    <= 1'b0;
      m_pulse <= 1'b0;
    end else begin
      btn_hist.push_back(btn_pause_raw);
      sw_hist.push_back(sw_student_raw);
      m_pulse <= settled(btn_hist, m_btn) & ~m_btn;
      m_btn   <= m_btn ^ settled(btn_hist, m_btn);
      m_sw    <= m_sw ^ settled(sw_hist, m_sw);
    end
  end

  // Drive inputs at the falling edge, then return just after the next rising edge.
  task automatic cyc(input logic b, input logic s);
    @(negedge clk);
    btn_pause_raw  = b;
    sw_student_raw = s;
    @(posedge clk);
    #1;
    if (pulse_pause === 1'b1) pulses++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      total++;
      if ({pulse_pause, btn_pause_level, sw_student} !== 3'b000)
        $display("FAIL reset_hold: got %b expected 000", {pulse_pause, btn_pause_level, sw_student});
      else passed++;
    end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1);
      total++;
      if ({pulse_pause, btn_pause_level, sw_student} !== {m_pulse, m_btn, m_sw})
        $display("FAIL reset_model cyc %0d: got %b expected %b", i,
                 {pulse_pause, btn_pause_level, sw_student}, {m_pulse, m_btn, m_sw});
      else passed++;
      if (i == 4 || i == 5) begin
        total++;
        if ({pulse_pause, btn_pause_level, sw_student} !== ((i == 5) ? 3'b111 : 3'b000))
          $display("FAIL reset_latency cyc %0d: got %b expected %b", i,
                   {pulse_pause, btn_pause_level, sw_student}, (i == 5) ? 3'b111 : 3'b000);
        else passed++;
      end
    end
    total++;
    if (pulses !== 1) $display("FAIL reset_pulse_count: got %0d expected 1", pulses);
    else passed++;
  endtask

  task automatic test_clean_press;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1);
      total++;
      if ({pulse_pause, btn_pause_level} !== {m_pulse, m_btn})
        $display("FAIL press_model cyc %0d: got %b expected %b", i,
                 {pulse_pause, btn_pause_level}, {m_pulse, m_btn});
      else passed++;
      total++;
      if ({pulse_pause, btn_pause_level} !== ((i < 5) ? 2'b00 : (i == 5) ? 2'b11 : 2'b01))
        $display("FAIL press_timing cyc %0d: got %b expected %b", i, {pulse_pause, btn_pause_level},
                 (i < 5) ? 2'b00 : (i == 5) ? 2'b11 : 2'b01);
      else passed++;
    end
  endtask

  task automatic test_release;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1);
      total++;
      if ({pulse_pause, btn_pause_level} !== ((i < 5) ? 2'b01 : 2'b00))
        $display("FAIL release_timing cyc %0d: got %b expected %b", i, {pulse_pause, btn_pause_level},
                 (i < 5) ? 2'b01 : 2'b00);
      else passed++;
    end
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
    total++;
    if (pulses !== 2) $display("FAIL release_pulse_count: got %0d expected 2", pulses);
    else passed++;
  endtask

  task automatic test_bounce;
    logic [9:0] pat;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1);
    pat = 10'b1110111011;
    pulses = 0;
    for (int i = 0; i < 22; i++) begin
      cyc((i < 10) ? pat[i] : 1'b1, 1'b1);
      total++;
      if ({pulse_pause, btn_pause_level} !== ((i < 12) ? 2'b00 : (i == 12) ? 2'b11 : 2'b01))
        $display("FAIL bounce cyc %0d: got %b expected %b", i, {pulse_pause, btn_pause_level},
                 (i < 12) ? 2'b00 : (i == 12) ? 2'b11 : 2'b01);
      else passed++;
    end
    total++;
    if (pulses !== 1) $display("FAIL bounce_pulse_count: got %0d expected 1", pulses);
    else passed++;
  endtask

  task automatic test_student;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, (i < 10) ? 1'b1 : 1'b0);
      total++;
      if (sw_student !== (((i >= 5) && (i < 15)) ? 1'b1 : 1'b0))
        $display("FAIL student_follow cyc %0d: got %b expected %b", i, sw_student,
                 ((i >= 5) && (i < 15)) ? 1'b1 : 1'b0);
      else passed++;
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, (i < 3) ? 1'b1 : 1'b0);
      total++;
      if (sw_student !== 1'b0)
        $display("FAIL student_glitch cyc %0d: got %b expected 0", i, sw_student);
      else passed++;
    end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1);
      total++;
      if ({btn_pause_level, sw_student} !== ((i < 5) ? 2'b00 : 2'b11))
        $display("FAIL simul_rise cyc %0d: got %b expected %b", i, {btn_pause_level, sw_student},
                 (i < 5) ? 2'b00 : 2'b11);
      else passed++;
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
    rst = 1'b1;
    #1;
    total++;
    if ({pulse_pause, btn_pause_level, sw_student} !== 3'b000)
      $display("FAIL midcount_reset: got %b expected 000", {pulse_pause, btn_pause_level, sw_student});
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1);
      total++;
      if ({pulse_pause, btn_pause_level, sw_student} !== ((i < 5) ? 3'b000 : (i == 5) ? 3'b111 : 3'b011))
        $display("FAIL midcount_requalify cyc %0d: got %b expected %b", i,
                 {pulse_pause, btn_pause_level, sw_student},
                 (i < 5) ? 3'b000 : (i == 5) ? 3'b111 : 3'b011);
      else passed++;
    end
  endtask

  task automatic test_random;
    logic b, s;
    int run_b, run_s;
    b = btn_pause_raw;
    s = sw_student_raw;
    run_b = 0;
    run_s = 0;
    for (int i = 0; i < 400; i++) begin
      if (run_b == 0) begin b = ~b; run_b = $urandom_range(7, 1); end
      if (run_s == 0) begin s = ~s; run_s = $urandom_range(7, 1); end
      run_b--;
      run_s--;
      cyc(b, s);
      total++;
      if ({pulse_pause, btn_pause_level, sw_student} !== {m_pulse, m_btn, m_sw})
        $display("FAIL random cyc %0d: got %b expected %b", i,
                 {pulse_pause, btn_pause_level, sw_student}, {m_pulse, m_btn, m_sw});
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_student();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
